// File: rtl/mdu_if.sv
// MDU bundle: EX request/MT path, HI/LO results and the external multiplier link.
// Modports: slave = mdu_ctrl, master = EX stage, mult = combinational multiplier.
interface mdu_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] mt_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_sign;
  logic [63:0] mul_product;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave (
    input  req_valid, op, src_a, src_b, flush, mthi_we, mtlo_we, mt_data, mul_product,
    output req_ready, mul_a, mul_b, mul_sign, busy, done, hi, lo
  );

  modport master (
    output req_valid, op, src_a, src_b, flush, mthi_we, mtlo_we, mt_data,
    input  req_ready, busy, done, hi, lo
  );

  modport mult (
    input  mul_a, mul_b, mul_sign,
    output mul_product
  );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU controller: drives the external multiplier, runs a restoring radix-2 divider,
// and owns the architectural HI/LO registers.
module mdu_ctrl #(
  parameter int unsigned MUL_WAIT = 1
) (
  input  logic  clk,
  input  logic  resetn,
  mdu_if.slave  bus
);

  // IDLE accept | MUL operands on multiplier | DIV one bit/cycle | FIX sign correct | DONE pulse
  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  localparam int unsigned CW = $clog2(MUL_WAIT + 1);

  state_e        state_q, state_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          mul_sign_q, mul_sign_d;
  logic          done_q, done_d;
  logic [CW-1:0] mul_cnt_q, mul_cnt_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   rem_q, rem_d;
  logic [31:0]   dvs_q, dvs_d;
  logic          q_neg_q, q_neg_d;
  logic          r_neg_q, r_neg_d;
  logic [5:0]    div_cnt_q, div_cnt_d;

  logic          accept;
  logic          signed_op;
  logic [32:0]   part_rem;
  logic [32:0]   trial;

  assign bus.req_ready = (state_q == S_IDLE) && !bus.flush;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.mul_sign  = mul_sign_q;

  assign accept    = bus.req_valid && bus.req_ready;
  assign signed_op = !bus.op[0];
  // Remainder shifted left with the next dividend bit: the 33-bit partial remainder.
  assign part_rem  = {rem_q, quo_q[31]};
  assign trial     = part_rem - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_sign_d = mul_sign_q;
    done_d     = 1'b0;
    mul_cnt_d  = mul_cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    div_cnt_d  = div_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.mthi_we) hi_d = bus.mt_data;
        if (bus.mtlo_we) lo_d = bus.mt_data;
        if (accept) begin
          if (!bus.op[1]) begin
            mul_a_d    = bus.src_a;
            mul_b_d    = bus.src_b;
            mul_sign_d = (bus.op == 2'b00);
            mul_cnt_d  = CW'(MUL_WAIT - 1);
            state_d    = S_MUL;
          end else if (bus.src_b == 32'd0) begin
            // Divide by zero: signal completion without touching HI/LO.
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            quo_d     = (signed_op && bus.src_a[31]) ? (~bus.src_a + 32'd1) : bus.src_a;
            dvs_d     = (signed_op && bus.src_b[31]) ? (~bus.src_b + 32'd1) : bus.src_b;
            rem_d     = 32'd0;
            q_neg_d   = signed_op && (bus.src_a[31] ^ bus.src_b[31]);
            r_neg_d   = signed_op && bus.src_a[31];
            div_cnt_d = 6'd31;
            state_d   = S_DIV;
          end
        end
      end

      S_MUL: begin
        if (mul_cnt_q == '0) begin
          hi_d    = bus.mul_product[63:32];
          lo_d    = bus.mul_product[31:0];
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          mul_cnt_d = mul_cnt_q - 1'b1;
        end
      end

      S_DIV: begin
        if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = part_rem[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        if (div_cnt_q == 6'd0) begin
          state_d = S_FIX;
        end else begin
          div_cnt_d = div_cnt_q - 6'd1;
        end
      end

      S_FIX: begin
        lo_d    = q_neg_q ? (~quo_q + 32'd1) : quo_q;
        hi_d    = r_neg_q ? (~rem_q + 32'd1) : rem_q;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel the in-flight op: no result write and no completion pulse.
    if (bus.flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      mul_sign_q <= 1'b0;
      done_q     <= 1'b0;
      mul_cnt_q  <= '0;
      quo_q      <= 32'd0;
      rem_q      <= 32'd0;
      dvs_q      <= 32'd0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      div_cnt_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_sign_q <= mul_sign_d;
      done_q     <= done_d;
      mul_cnt_q  <= mul_cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      div_cnt_q  <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and completion cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_mdu_ctrl;
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  mdu_if bus ();

  mdu_ctrl #(.MUL_WAIT(1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational multiplier model: low 64 bits of the sign/zero-extended product.
  logic [63:0] ext_a, ext_b;
  always_comb begin
    ext_a = {{32{bus.mul_sign & bus.mul_a[31]}}, bus.mul_a};
    ext_b = {{32{bus.mul_sign & bus.mul_b[31]}}, bus.mul_b};
    bus.mul_product = ext_a * ext_b;
  end

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int   op_id = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      exp_t e;
      chk("done_vs_ready", 64'(bus.req_ready), 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        $display("op#%0d done at cycle %0d", e.id, cyc);
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("result_hi", 64'(bus.hi), 64'(e.hi));
        chk("result_lo", 64'(bus.lo), 64'(e.lo));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                       input logic mthi, input logic mtlo, input logic [31:0] mtd);
    exp_t e;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.op        = o;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.mthi_we   = mthi;
    bus.mtlo_we   = mtlo;
    bus.mt_data   = mtd;
    @(negedge clk);
    chk("req_ready_at_accept", 64'(bus.req_ready), 64'd1);
    op_id++;
    e.hi = ehi; e.lo = elo; e.cyc = cyc + lat; e.id = op_id;
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.mthi_we   = 1'b0;
    bus.mtlo_we   = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got no done in %0d cycles expected done", budget);
    end
  endtask

  task automatic mt_write(input logic mthi, input logic mtlo, input logic [31:0] d);
    @(posedge clk); #1;
    bus.mthi_we = mthi;
    bus.mtlo_we = mtlo;
    bus.mt_data = d;
    @(posedge clk); #1;
    bus.mthi_we = 1'b0;
    bus.mtlo_we = 1'b0;
  endtask

  initial begin
    resetn        = 1'b0;
    bus.req_valid = 1'b0;
    bus.op        = 2'b00;
    bus.src_a     = 32'd0;
    bus.src_b     = 32'd0;
    bus.flush     = 1'b0;
    bus.mthi_we   = 1'b0;
    bus.mtlo_we   = 1'b0;
    bus.mt_data   = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mul_sign", 64'(bus.mul_sign), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(bus.req_ready), 64'd1);

    // 1: MULTU max x max
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("multu_sign", 64'(bus.mul_sign), 64'd0);
    chk("multu_mul_a", 64'(bus.mul_a), 64'hFFFF_FFFF);
    chk("multu_busy", 64'(bus.busy), 64'd1);
    wait_done(10);

    // 2: MULT -3 x 5, then back-to-back MULT 2 x 3 in the cycle after done
    issue(2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 2, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("mult_sign", 64'(bus.mul_sign), 64'd1);
    wait_done(10);
    issue(2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 2, 1'b0, 1'b0, 32'd0);
    wait_done(10);

    // 3: divides
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    chk("div_ready_busy", 64'(bus.req_ready), 64'd0);
    wait_done(50);
    issue(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 34, 1'b0, 1'b0, 32'd0);
    wait_done(50);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34, 1'b0, 1'b0, 32'd0);
    wait_done(50);

    // 4: MTHI+MTLO together write both, then MTLO alone; DIVU by zero keeps HI/LO
    mt_write(1'b1, 1'b1, 32'h0000_0011);
    @(negedge clk);
    chk("mt_both_hi", 64'(bus.hi), 64'h11);
    chk("mt_both_lo", 64'(bus.lo), 64'h11);
    mt_write(1'b0, 1'b1, 32'h0000_0022);
    @(negedge clk);
    chk("mt_hi", 64'(bus.hi), 64'h11);
    chk("mt_lo", 64'(bus.lo), 64'h22);
    issue(2'b11, 32'd5, 32'd0, 32'h11, 32'h22, 1, 1'b0, 1'b0, 32'd0);
    wait_done(10);
    @(posedge clk); #1;
    @(negedge clk);
    chk("divz_busy_after", 64'(bus.busy), 64'd0);
    chk("divz_hi", 64'(bus.hi), 64'h11);

    // 5: DIV 100/3 flushed at iteration 10; MT while busy is ignored
    issue(2'b10, 32'd100, 32'd3, 32'd0, 32'd0, 34, 1'b0, 1'b0, 32'd0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge clk);
    #1;
    bus.flush   = 1'b1;
    bus.mthi_we = 1'b1;
    bus.mt_data = 32'h0000_DEAD;
    @(negedge clk);
    chk("flush_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    bus.flush   = 1'b0;
    bus.mthi_we = 1'b0;
    @(negedge clk);
    chk("flush_busy_next", 64'(bus.busy), 64'd0);
    chk("flush_ready_next", 64'(bus.req_ready), 64'd1);
    chk("flush_hi_kept", 64'(bus.hi), 64'h11);
    chk("flush_lo_kept", 64'(bus.lo), 64'h22);
    repeat (30) @(negedge clk);
    // flush in IDLE drops a concurrent request
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.op        = 2'b11;
    bus.flush     = 1'b1;
    @(negedge clk);
    chk("idle_flush_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    @(negedge clk);
    chk("idle_flush_dropped", 64'(bus.busy), 64'd0);
    // DIVU 100/3 with a concurrent MTHI that the result later overwrites
    issue(2'b11, 32'd100, 32'd3, 32'd1, 32'd33, 34, 1'b1, 1'b0, 32'h0000_0055);
    @(negedge clk);
    chk("mt_with_accept_hi", 64'(bus.hi), 64'h55);
    wait_done(50);

    // 6: reset during DIV iteration 20
    issue(2'b10, 32'd1000, 32'd7, 32'd6, 32'd142, 34, 1'b0, 1'b0, 32'd0);
    repeat (19) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 64'(bus.req_ready), 64'd1);
    repeat (40) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
